// File: rtl/writeback_arbiter_if.sv
// Writeback arbiter bus: per-requester request lanes plus the single output slot
// handshake toward the core.
interface writeback_arbiter_if #(
  parameter int NUM_REQ  = 3,
  parameter int XLEN     = 64,
  parameter int PT_WIDTH = 16
);
  localparam int SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]               req_valid;
  logic [NUM_REQ-1:0][XLEN-1:0]     req_value;
  logic [NUM_REQ-1:0][4:0]          req_register;
  logic [NUM_REQ-1:0][PT_WIDTH-1:0] req_passthrough;
  logic [NUM_REQ-1:0]               req_acknowledge;
  logic                             wb_valid;
  logic                             wb_ready;
  logic [XLEN-1:0]                  wb_value;
  logic [4:0]                       wb_register;
  logic [PT_WIDTH-1:0]              wb_passthrough;
  logic [SRC_W-1:0]                 wb_source;

  // Requesters and the consuming core.
  modport master (
    output req_valid, req_value, req_register, req_passthrough, wb_ready,
    input  req_acknowledge, wb_valid, wb_value, wb_register, wb_passthrough, wb_source
  );

  // The arbiter.
  modport slave (
    input  req_valid, req_value, req_register, req_passthrough, wb_ready,
    output req_acknowledge, wb_valid, wb_value, wb_register, wb_passthrough, wb_source
  );
endinterface

// File: rtl/writeback_arbiter.sv
// Round-robin arbiter funnelling NUM_REQ writeback requesters into one registered
// output slot; drain and refill can happen in the same cycle.
module writeback_arbiter #(
  parameter int NUM_REQ  = 3,
  parameter int XLEN     = 64,
  parameter int PT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  writeback_arbiter_if.slave    bus
);
  localparam int SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} slot_state_t;

  slot_state_t         r_state;
  logic [SRC_W-1:0]    r_rr_ptr;
  logic [XLEN-1:0]     r_value;
  logic [4:0]          r_register;
  logic [PT_WIDTH-1:0] r_passthrough;
  logic [SRC_W-1:0]    r_source;

  logic                w_accept;
  logic                w_grant_any;
  logic [SRC_W-1:0]    w_grant_idx;
  logic [SRC_W-1:0]    w_next_ptr;

  assign w_accept = !rst && !flush && ((r_state == EMPTY) || bus.wb_ready);

  // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    int idx;
    idx         = 0;
    w_grant_any = 1'b0;
    w_grant_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(r_rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (w_accept && !w_grant_any && bus.req_valid[idx]) begin
        w_grant_any = 1'b1;
        w_grant_idx = SRC_W'(idx);
      end
    end
  end

  assign w_next_ptr = (w_grant_idx == SRC_W'(NUM_REQ - 1)) ? '0 : w_grant_idx + SRC_W'(1);

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ack
      assign bus.req_acknowledge[gi] = w_grant_any && (w_grant_idx == SRC_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_state  <= EMPTY;
      r_rr_ptr <= '0;
    end else if (w_grant_any) begin
      r_state       <= FULL;
      r_rr_ptr      <= w_next_ptr;
      r_value       <= bus.req_value[w_grant_idx];
      r_register    <= bus.req_register[w_grant_idx];
      r_passthrough <= bus.req_passthrough[w_grant_idx];
      r_source      <= w_grant_idx;
    end else if ((r_state == FULL) && bus.wb_ready) begin
      r_state <= EMPTY;
    end
  end

  // Outputs come only from slot registers, never from the request lanes.
  assign bus.wb_valid       = (r_state == FULL);
  assign bus.wb_value       = r_value;
  assign bus.wb_register    = r_register;
  assign bus.wb_passthrough = r_passthrough;
  assign bus.wb_source      = r_source;
endmodule

// File: tb/tb_writeback_arbiter.sv
// Bench for writeback_arbiter: directed scenarios plus randomized traffic checked
// against a transaction-level model of the slot and round-robin pointer.
module tb_writeback_arbiter;
  localparam int NUM_REQ  = 3;
  localparam int XLEN     = 64;
  localparam int PT_WIDTH = 16;

  logic clk;
  logic rst;
  logic flush;
  int   total;
  int   bad;

  writeback_arbiter_if #(.NUM_REQ(NUM_REQ), .XLEN(XLEN), .PT_WIDTH(PT_WIDTH)) bus();

  writeback_arbiter #(.NUM_REQ(NUM_REQ), .XLEN(XLEN), .PT_WIDTH(PT_WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: slot contents and the next-search start index.
  bit                  m_full;
  int                  m_ptr;
  logic [XLEN-1:0]     m_val;
  logic [4:0]          m_reg;
  logic [PT_WIDTH-1:0] m_pt;
  int                  m_src;
  int                  exp_grant;
  logic [NUM_REQ-1:0]  exp_ack;

  task automatic predict();
    int idx;
    exp_grant = -1;
    if (!rst && !flush && (!m_full || bus.wb_ready)) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = (m_ptr + k) % NUM_REQ;
        if (exp_grant < 0 && bus.req_valid[idx]) exp_grant = idx;
      end
    end
    exp_ack = '0;
    if (exp_grant >= 0) exp_ack[exp_grant] = 1'b1;
  endtask

  task automatic tick();
    predict();
    @(posedge clk);
    if (rst || flush) begin
      m_full = 1'b0;
      m_ptr  = 0;
    end else if (exp_grant >= 0) begin
      m_full = 1'b1;
      m_val  = bus.req_value[exp_grant];
      m_reg  = bus.req_register[exp_grant];
      m_pt   = bus.req_passthrough[exp_grant];
      m_src  = exp_grant;
      m_ptr  = (exp_grant + 1) % NUM_REQ;
      $display("grant src=%0d value=%h reg=%0d pt=%h", exp_grant, m_val, m_reg, m_pt);
    end else if (m_full && bus.wb_ready) begin
      m_full = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    flush = 1'b0;
    bus.req_valid = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    flush = 1'b0;
    bus.req_valid = '1;
    bus.wb_ready = 1'b1;
    tick();
    tick();
    #1;
    total++;
    if (bus.req_acknowledge !== 3'b000) begin
      bad++; $display("FAIL reset_ack got=%b want=000", bus.req_acknowledge);
    end
    total++;
    if (bus.wb_valid !== 1'b0) begin
      bad++; $display("FAIL reset_wb_valid got=%b want=0", bus.wb_valid);
    end
    rst = 1'b0;
    bus.req_valid = '0;
    #1;
    tick();
  endtask

  task automatic test_single();
    do_reset();
    bus.req_valid = 3'b001;
    bus.req_value[0] = 64'h55;
    bus.req_register[0] = 5'd7;
    bus.req_passthrough[0] = 16'hABCD;
    bus.wb_ready = 1'b1;
    #1;
    total++;
    if (bus.req_acknowledge !== 3'b001) begin
      bad++; $display("FAIL single_ack got=%b want=001", bus.req_acknowledge);
    end
    tick();
    bus.req_valid = '0;
    #1;
    total++;
    if (bus.wb_valid !== 1'b1 || bus.wb_value !== 64'h55 || bus.wb_register !== 5'd7 ||
        bus.wb_source !== 2'd0 || bus.wb_passthrough !== 16'hABCD) begin
      bad++;
      $display("FAIL single_wb got valid=%b value=%h reg=%0d src=%0d pt=%h want 1 55 7 0 abcd",
               bus.wb_valid, bus.wb_value, bus.wb_register, bus.wb_source, bus.wb_passthrough);
    end
    tick();
    #1;
    total++;
    if (bus.wb_valid !== 1'b0) begin
      bad++; $display("FAIL single_drain got=%b want=0", bus.wb_valid);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_value[i] = 64'(100 + i);
      bus.req_register[i] = 5'(i + 1);
    end
    bus.req_valid = 3'b111;
    bus.wb_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      total++;
      if (bus.req_acknowledge !== (3'b001 << (c % NUM_REQ))) begin
        bad++; $display("FAIL rr_ack cycle=%0d got=%b want=%b", c, bus.req_acknowledge,
                        3'b001 << (c % NUM_REQ));
      end
      if (c > 0) begin
        total++;
        if (bus.wb_valid !== 1'b1 || int'(bus.wb_source) != (c - 1) % NUM_REQ ||
            bus.wb_value !== 64'(100 + (c - 1) % NUM_REQ)) begin
          bad++; $display("FAIL rr_wb cycle=%0d got src=%0d value=%0d want src=%0d",
                          c, bus.wb_source, bus.wb_value, (c - 1) % NUM_REQ);
        end
      end
      tick();
    end
    bus.req_valid = '0;
    #1;
    total++;
    if (bus.wb_valid !== 1'b1 || bus.wb_source !== 2'd2) begin
      bad++; $display("FAIL rr_last got valid=%b src=%0d want 1 2", bus.wb_valid, bus.wb_source);
    end
    tick();
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.req_value[1] = 64'h11;
    bus.req_value[2] = 64'h22;
    bus.req_value[0] = 64'h00;
    bus.req_valid = 3'b010;
    bus.wb_ready = 1'b1;
    tick();
    bus.req_valid = 3'b101;
    bus.wb_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      total++;
      if (bus.req_acknowledge !== 3'b000 || bus.wb_valid !== 1'b1 ||
          bus.wb_source !== 2'd1 || bus.wb_value !== 64'h11) begin
        bad++; $display("FAIL bp_hold cycle=%0d got ack=%b valid=%b src=%0d value=%h want 000 1 1 11",
                        c, bus.req_acknowledge, bus.wb_valid, bus.wb_source, bus.wb_value);
      end
      tick();
    end
    bus.wb_ready = 1'b1;
    #1;
    total++;
    if (bus.req_acknowledge !== 3'b100) begin
      bad++; $display("FAIL bp_release_ack got=%b want=100", bus.req_acknowledge);
    end
    tick();
    bus.req_valid = '0;
    #1;
    total++;
    if (bus.wb_valid !== 1'b1 || bus.wb_source !== 2'd2 || bus.wb_value !== 64'h22) begin
      bad++; $display("FAIL bp_refill got valid=%b src=%0d value=%h want 1 2 22",
                      bus.wb_valid, bus.wb_source, bus.wb_value);
    end
    tick();
  endtask

  task automatic test_flush();
    do_reset();
    bus.req_valid = 3'b010;
    bus.wb_ready = 1'b1;
    tick();
    bus.req_valid = 3'b111;
    flush = 1'b1;
    #1;
    total++;
    if (bus.req_acknowledge !== 3'b000) begin
      bad++; $display("FAIL flush_ack got=%b want=000", bus.req_acknowledge);
    end
    tick();
    flush = 1'b0;
    #1;
    total++;
    if (bus.wb_valid !== 1'b0 || bus.req_acknowledge !== 3'b001) begin
      bad++; $display("FAIL flush_after got valid=%b ack=%b want 0 001",
                      bus.wb_valid, bus.req_acknowledge);
    end
    tick();
    bus.req_valid = '0;
    #1;
    total++;
    if (bus.wb_valid !== 1'b1 || bus.wb_source !== 2'd0) begin
      bad++; $display("FAIL flush_first got valid=%b src=%0d want 1 0", bus.wb_valid, bus.wb_source);
    end
    tick();
  endtask

  task automatic test_withdrawal();
    do_reset();
    bus.req_value[0] = 64'h77;
    bus.req_valid = 3'b001;
    bus.wb_ready = 1'b1;
    tick();
    bus.wb_ready = 1'b0;
    bus.req_valid = 3'b010;
    #1;
    total++;
    if (bus.req_acknowledge !== 3'b000) begin
      bad++; $display("FAIL wd_ack got=%b want=000", bus.req_acknowledge);
    end
    tick();
    bus.req_valid = 3'b000;
    for (int c = 0; c < 3; c++) begin
      #1;
      total++;
      if (bus.req_acknowledge !== 3'b000 || bus.wb_valid !== 1'b1 ||
          bus.wb_source !== 2'd0 || bus.wb_value !== 64'h77) begin
        bad++; $display("FAIL wd_hold cycle=%0d got ack=%b valid=%b src=%0d value=%h want 000 1 0 77",
                        c, bus.req_acknowledge, bus.wb_valid, bus.wb_source, bus.wb_value);
      end
      tick();
    end
    bus.wb_ready = 1'b1;
    tick();
    #1;
    total++;
    if (bus.wb_valid !== 1'b0 || bus.req_acknowledge !== 3'b000) begin
      bad++; $display("FAIL wd_drain got valid=%b ack=%b want 0 000", bus.wb_valid, bus.req_acknowledge);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        bus.req_value[i] = {$urandom, $urandom};
        bus.req_register[i] = 5'($urandom_range(0, 31));
        bus.req_passthrough[i] = 16'($urandom);
      end
      bus.req_valid = 3'($urandom);
      bus.wb_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 24) == 0);
      rst = ($urandom_range(0, 49) == 0);
      #1;
      predict();
      total++;
      if (bus.req_acknowledge !== exp_ack || bus.wb_valid !== m_full) begin
        bad++; $display("FAIL rand_ctl cycle=%0d got ack=%b valid=%b want ack=%b valid=%b",
                        c, bus.req_acknowledge, bus.wb_valid, exp_ack, m_full);
      end
      if (m_full) begin
        total++;
        if (bus.wb_value !== m_val || bus.wb_register !== m_reg ||
            bus.wb_passthrough !== m_pt || int'(bus.wb_source) != m_src) begin
          bad++; $display("FAIL rand_data cycle=%0d got %h/%0d/%h/%0d want %h/%0d/%h/%0d", c,
                          bus.wb_value, bus.wb_register, bus.wb_passthrough, bus.wb_source,
                          m_val, m_reg, m_pt, m_src);
        end
      end
      tick();
    end
    rst = 1'b0;
    flush = 1'b0;
  endtask

  initial begin
    total = 0;
    bad = 0;
    m_full = 1'b0;
    m_ptr = 0;
    m_src = 0;
    m_val = '0;
    m_reg = '0;
    m_pt = '0;
    rst = 1'b1;
    flush = 1'b0;
    bus.req_valid = '0;
    bus.req_value = '0;
    bus.req_register = '0;
    bus.req_passthrough = '0;
    bus.wb_ready = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_flush();
    test_withdrawal();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
